// File: rtl/wdt32_counter.sv
// Prescaled 32-bit watchdog core: first timeout sets WDOV,
// a second unserviced timeout raises a sticky WDRST.
module wdt32_counter #(
  parameter int unsigned PRESCALE = 1,
  parameter bit          RST_EN   = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] WDLOAD,
  input  logic        WDEN,
  input  logic        WDOVCLR,
  output logic [31:0] WDTMR,
  output logic        WDOV,
  output logic        WDRST
);

  localparam int unsigned PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_DIS,
    S_RUN,
    S_EXP,
    S_RRQ
  } state_t;

  state_t        state;
  logic [PW-1:0] psc;
  logic          clr_q;
  logic [31:0]   load_q;

  logic tick;
  logic kick;
  logic ldchg;
  logic expire;

  assign tick   = (psc == PSC_MAX);
  assign kick   = WDOVCLR & ~clr_q;
  assign ldchg  = (WDLOAD != load_q);
  assign expire = tick & (WDTMR == 32'd0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= S_DIS;
      psc    <= '0;
      clr_q  <= 1'b0;
      load_q <= '0;
      WDTMR  <= '0;
      WDOV   <= 1'b0;
      WDRST  <= 1'b0;
    end else begin
      clr_q  <= WDOVCLR;
      load_q <= WDLOAD;
      if (state == S_RRQ) begin
        WDOV  <= 1'b1;
        WDRST <= 1'b1;
      end else if (kick) begin
        WDOV  <= 1'b0;
        WDTMR <= WDLOAD;
        psc   <= '0;
        state <= WDEN ? S_RUN : S_DIS;
      end else if (state == S_DIS) begin
        if (WDEN) begin
          WDTMR <= WDLOAD;
          psc   <= '0;
          state <= S_RUN;
        end
      end else if (!WDEN) begin
        state <= S_DIS;
      end else begin
        psc <= tick ? '0 : psc + 1'b1;
        // Expiry always reloads, so the count never wraps below zero
        if (expire) begin
          WDTMR <= WDLOAD;
          if (state == S_RUN) begin
            WDOV  <= 1'b1;
            state <= S_EXP;
          end else if (RST_EN) begin
            WDRST <= 1'b1;
            state <= S_RRQ;
          end
        end else if (ldchg) begin
          WDTMR <= WDLOAD;
          psc   <= '0;
        end else if (tick) begin
          WDTMR <= WDTMR - 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wdt32_counter.sv
// Directed bench for wdt32_counter: vector table plus
// hand sequences for expiry, reset request and prescaling.
module tb_wdt32_counter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] WDLOAD;
  logic        WDEN;
  logic        WDOVCLR;

  logic [31:0] tmr1, tmr4, tmr4n;
  logic        ov1, ov4, ov4n;
  logic        rst1, rst4, rst4n;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  wdt32_counter #(.PRESCALE(1), .RST_EN(1'b1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .WDLOAD(WDLOAD),
    .WDEN(WDEN), .WDOVCLR(WDOVCLR),
    .WDTMR(tmr1), .WDOV(ov1), .WDRST(rst1)
  );

  wdt32_counter #(.PRESCALE(4), .RST_EN(1'b1)) dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .WDLOAD(WDLOAD),
    .WDEN(WDEN), .WDOVCLR(WDOVCLR),
    .WDTMR(tmr4), .WDOV(ov4), .WDRST(rst4)
  );

  wdt32_counter #(.PRESCALE(4), .RST_EN(1'b0)) dut4n (
    .PCLK(PCLK), .PRESETn(PRESETn), .WDLOAD(WDLOAD),
    .WDEN(WDEN), .WDOVCLR(WDOVCLR),
    .WDTMR(tmr4n), .WDOV(ov4n), .WDRST(rst4n)
  );

  typedef struct {
    logic        en;
    logic        clr;
    logic [31:0] load;
    logic [31:0] tmr;
    logic        ov;
    logic        rst;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic en, logic clr,
                              int load, int tmr,
                              logic ov, logic rst);
    vec_t v;
    v.en   = en;
    v.clr  = clr;
    v.load = 32'(load);
    v.tmr  = 32'(tmr);
    v.ov   = ov;
    v.rst  = rst;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk1(string name, logic [31:0] t,
                      logic o, logic r);
    chk({name, ".tmr"}, tmr1, t);
    chk({name, ".ov"}, {31'd0, ov1}, {31'd0, o});
    chk({name, ".rst"}, {31'd0, rst1}, {31'd0, r});
  endtask

  task automatic drive(logic en, logic clr, int load);
    WDEN    = en;
    WDOVCLR = clr;
    WDLOAD  = 32'(load);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 5, 5, 0, 0);
    tbl[1]  = mk(1, 0, 5, 4, 0, 0);
    tbl[2]  = mk(1, 0, 5, 3, 0, 0);
    tbl[3]  = mk(1, 0, 5, 2, 0, 0);
    tbl[4]  = mk(1, 0, 5, 1, 0, 0);
    tbl[5]  = mk(1, 0, 5, 0, 0, 0);
    tbl[6]  = mk(1, 0, 5, 5, 1, 0);
    tbl[7]  = mk(1, 1, 5, 5, 0, 0);
    tbl[8]  = mk(1, 0, 5, 4, 0, 0);
    tbl[9]  = mk(1, 0, 5, 3, 0, 0);
    tbl[10] = mk(1, 0, 5, 2, 0, 0);
    tbl[11] = mk(1, 1, 5, 5, 0, 0);
    tbl[12] = mk(1, 1, 5, 4, 0, 0);
    tbl[13] = mk(1, 1, 5, 3, 0, 0);
    tbl[14] = mk(1, 0, 5, 2, 0, 0);
    tbl[15] = mk(1, 0, 9, 9, 0, 0);
    tbl[16] = mk(1, 0, 9, 8, 0, 0);

    PRESETn = 1'b0;
    drive(0, 0, 5);
    repeat (2) step();
    chk1("reset", 32'd0, 1'b0, 1'b0);
    chk("reset.ov4", {31'd0, ov4}, 32'd0);
    PRESETn = 1'b1;
    step();
    chk1("disabled", 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].en, tbl[i].clr, int'(tbl[i].load));
      step();
      chk1($sformatf("vec%0d", i), tbl[i].tmr,
           tbl[i].ov, tbl[i].rst);
    end

    // freeze while disabled, resume from reload
    for (int i = 7; i >= 3; i--) begin
      drive(1, 0, 9);
      step();
      chk("pre_dis.tmr", tmr1, 32'(i));
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 9);
      step();
      chk1($sformatf("frozen%0d", i), 32'd3, 1'b0, 1'b0);
    end
    drive(1, 0, 9);
    step();
    chk1("reenable", 32'd9, 1'b0, 1'b0);

    // kick coinciding with the zero tick
    drive(1, 0, 5);
    step();
    chk("ldchg.tmr", tmr1, 32'd5);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk("k5.tmr", tmr1, 32'(i));
    end
    drive(1, 1, 5);
    step();
    chk1("kick_at_zero", 32'd5, 1'b0, 1'b0);
    drive(1, 0, 5);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk1("k5b", 32'(i), 1'b0, 1'b0);
    end
    step();
    chk1("first_expiry", 32'd5, 1'b1, 1'b0);
    drive(1, 1, 5);
    step();
    chk1("kick_expired", 32'd5, 1'b0, 1'b0);
    drive(1, 0, 5);
    step();
    chk("after_kick.tmr", tmr1, 32'd4);

    // unserviced double timeout
    drive(1, 0, 3);
    step();
    chk1("load3", 32'd3, 1'b0, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      step();
      chk1("s3a", 32'(i), 1'b0, 1'b0);
    end
    step();
    chk1("edge4_ov", 32'd3, 1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      step();
      chk1("s3b", 32'(i), 1'b1, 1'b0);
    end
    step();
    chk1("edge8_rst", 32'd3, 1'b1, 1'b1);
    drive(0, 1, 3);
    step();
    chk1("rrq_ignore1", 32'd3, 1'b1, 1'b1);
    drive(1, 0, 7);
    step();
    chk1("rrq_ignore2", 32'd3, 1'b1, 1'b1);
    drive(0, 0, 0);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk1("async_reset", 32'd0, 1'b0, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // prescaled instances, WDLOAD=0
    drive(1, 0, 0);
    repeat (4) step();
    chk("p4.ov_early", {31'd0, ov4}, 32'd0);
    step();
    chk("p4.ov", {31'd0, ov4}, 32'd1);
    chk("p4n.ov", {31'd0, ov4n}, 32'd1);
    chk("p4.tmr", tmr4, 32'd0);
    repeat (3) step();
    chk("p4.rst_early", {31'd0, rst4}, 32'd0);
    step();
    chk("p4.rst", {31'd0, rst4}, 32'd1);
    chk("p4n.rst", {31'd0, rst4n}, 32'd0);
    repeat (40) step();
    chk("p4.rst_hold", {31'd0, rst4}, 32'd1);
    chk("p4n.rst_hold", {31'd0, rst4n}, 32'd0);
    chk("p4n.ov_hold", {31'd0, ov4n}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
